sequential_subtractor_64: RTL



---
 rtl/sub_pkg.sv | 17 +
 rtl/subtractor_slice.sv | 25 ++
 rtl/sequential_subtractor_64.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the sliced 64-bit subtractor.
// Provides the FSM state enum, datapath width and slice-count helper.
package sub_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int nslice(input int w);
    return DATA_W / w;
  endfunction

endpackage

// File: rtl/subtractor_slice.sv
// Combinational SLICE_W-bit slice computing a + ~b + cin.
// Ports: a, b, cin in; d, cout, msb_cin (carry into slice MSB) out.
module subtractor_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] d,
  output logic               cout,
  output logic               msb_cin
);

  logic [SLICE_W:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, cin};
  end

  assign d    = sum[SLICE_W-1:0];
  assign cout = sum[SLICE_W];
  // carry into the MSB recovered from the MSB sum bit
  assign msb_cin = a[SLICE_W-1] ^ ~b[SLICE_W-1] ^ d[SLICE_W-1];

endmodule

// File: rtl/sequential_subtractor_64.sv
// Multi-cycle 64-bit subtractor: diff = a - b - bin, one slice per clock.
// Ports: clk, rst_n, in_valid/in_ready, a, b, bin, out_valid/out_ready,
// diff, bout; ovf (signed overflow) only when SUB_OVERFLOW_EN is defined.
module sequential_subtractor_64
  import sub_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic              ovf
`endif
);

  localparam int NSLICE = nslice(SLICE_W);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  sub_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] diff_q, diff_d;
  logic              carry_q, carry_d;
  logic              bout_q, bout_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [SLICE_W-1:0] s_a, s_b, s_d;
  logic               s_cout, s_msb_cin;
  logic               last;

  assign s_a  = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign s_b  = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign last = (idx_q == IDX_W'(NSLICE-1));

  subtractor_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .a      (s_a),
    .b      (s_b),
    .cin    (carry_q),
    .d      (s_d),
    .cout   (s_cout),
    .msb_cin(s_msb_cin)
  );

`ifdef SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
`else
  logic unused_msb_cin;
  assign unused_msb_cin = s_msb_cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    idx_d   = idx_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          // borrow travels as an inverted carry
          carry_d = ~bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[int'(idx_q)*SLICE_W +: SLICE_W] = s_d;
        carry_d = s_cout;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          bout_d  = ~s_cout;
          idx_d   = '0;
          state_d = DONE;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = s_msb_cin ^ s_cout;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      idx_q   <= idx_d;
    end
  end

`ifdef SUB_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule
